// File: rtl/xor_pipe.sv
// xor_pipe: XOR-family ALU feeding a 2-entry (main + skid) output buffer with registered in_ready.
// Optional parity output out_par is enabled by defining XOR_PIPE_PARITY_EN.
module xor_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef XOR_PIPE_PARITY_EN
    ,
    output logic             out_par
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state;
    occ_t             state_nxt;
    logic [WIDTH-1:0] skid;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] x_c;
    logic [WIDTH-1:0] res_c;
    logic             accept_c;
    logic             consume_c;
    logic             load_main;
    logic             load_skid;
    logic             move_skid;

    assign accept_c  = in_valid & in_ready;
    assign consume_c = out_valid & out_ready;

    // Operation select; mode 11 returns the post-update accumulator value.
    always_comb begin
        x_c   = a ^ b;
        res_c = x_c;
        case (mode)
            2'b00:   res_c = x_c;
            2'b01:   res_c = ~x_c;
            2'b10:   res_c = WIDTH'(^x_c);
            default: res_c = acc ^ x_c;
        endcase
    end

    // Buffer occupancy: a simultaneous accept+consume with one entry replaces main in place.
    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept_c) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept_c && consume_c) begin
                    load_main = 1'b1;
                end else if (consume_c) begin
                    state_nxt = EMPTY;
                end else if (accept_c) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end
            end
            FULL: begin
                if (consume_c) begin
                    state_nxt = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= '0;
            skid <= '0;
            acc  <= '0;
        end else begin
            if (load_main) begin
                out <= res_c;
            end else if (move_skid) begin
                out <= skid;
            end
            if (load_skid) begin
                skid <= res_c;
            end
            if (accept_c && (mode == 2'b11)) begin
                acc <= acc ^ x_c;
            end
        end
    end

`ifdef XOR_PIPE_PARITY_EN
    logic skid_par;

    // Parity is computed at acceptance and travels through the buffer alongside its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par  <= 1'b0;
            skid_par <= 1'b0;
        end else begin
            if (load_main) begin
                out_par <= ^res_c;
            end else if (move_skid) begin
                out_par <= skid_par;
            end
            if (load_skid) begin
                skid_par <= ^res_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xor_pipe.sv
// Self-checking bench for xor_pipe (WIDTH=8): queue-based reference model plus directed scenarios.
module tb_xor_pipe;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
`ifdef XOR_PIPE_PARITY_EN
    logic         out_par;
`endif

    int           n_checks;
    int           n_fail;
    logic [W-1:0] exp_q[$];
`ifdef XOR_PIPE_PARITY_EN
    logic         par_q[$];
`endif
    logic [W-1:0] acc_m;
    logic         obs_valid;
    logic [W-1:0] obs_out;
    int           n_consumed;

    xor_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef XOR_PIPE_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the arithmetic rules, accumulator updated only by accepted mode-3 beats.
    function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [1:0] mm);
        logic [W-1:0] r;
        int ones;
        ones = 0;
        for (int i = 0; i < int'(W); i++) ones += int'((ma[i] != mb[i]) ? 1 : 0);
        case (mm)
            2'd0: r = ma ^ mb;
            2'd1: r = ~(ma ^ mb);
            2'd2: r = W'(ones % 2);
            default: begin
                acc_m = acc_m ^ ma ^ mb;
                r = acc_m;
            end
        endcase
        return r;
    endfunction

    // One clock: check outputs against the model at the falling edge, then advance the model.
    task automatic cycle(output logic accepted);
        logic cons;
        @(negedge clk);
        n_checks++;
        if (out_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
        end
        n_checks++;
        if (in_ready !== (exp_q.size() < 2)) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b (occupancy %0d)", in_ready,
                     exp_q.size() < 2, exp_q.size());
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            if (out !== exp_q[0]) begin
                n_fail++;
                $display("FAIL out_data: got %h expected %h", out, exp_q[0]);
            end
`ifdef XOR_PIPE_PARITY_EN
            n_checks++;
            if (out_par !== par_q[0]) begin
                n_fail++;
                $display("FAIL out_par: got %b expected %b", out_par, par_q[0]);
            end
`endif
        end
        obs_valid = out_valid;
        obs_out   = out;
        accepted  = in_valid && (exp_q.size() < 2);
        cons      = out_ready && (exp_q.size() != 0);
        if (cons) begin
            void'(exp_q.pop_front());
`ifdef XOR_PIPE_PARITY_EN
            void'(par_q.pop_front());
`endif
            n_consumed++;
        end
        if (accepted) begin
            logic [W-1:0] r;
            r = model(a, b, mode);
            exp_q.push_back(r);
`ifdef XOR_PIPE_PARITY_EN
            par_q.push_back(^r);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; mode = 2'd0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
`ifdef XOR_PIPE_PARITY_EN
        par_q.delete();
`endif
        acc_m = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic acc_o;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; mode = 2'd0;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b r=%b out=%h expected v=0 r=1 out=00",
                     out_valid, in_ready, out);
        end
`ifdef XOR_PIPE_PARITY_EN
        n_checks++;
        if (out_par !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_par: got %b expected 0", out_par);
        end
`endif
        exp_q.delete();
`ifdef XOR_PIPE_PARITY_EN
        par_q.delete();
`endif
        acc_m = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(acc_o);
    endtask

    task automatic beat(input logic [W-1:0] ba, input logic [W-1:0] bb, input logic [1:0] bm);
        logic acc_o;
        in_valid = 1'b1; a = ba; b = bb; mode = bm;
        cycle(acc_o);
        in_valid = 1'b0;
    endtask

    task automatic test_modes();
        logic acc_o;
        logic [W-1:0] vec_a[3] = '{8'hA5, 8'hFF, 8'h07};
        logic [W-1:0] vec_b[3] = '{8'h0F, 8'h00, 8'h00};
        logic [1:0]   vec_m[3] = '{2'd0, 2'd1, 2'd2};
        logic [W-1:0] vec_e[3] = '{8'hAA, 8'h00, 8'h01};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(vec_a[i], vec_b[i], vec_m[i]);
            cycle(acc_o);
            n_checks++;
            if (obs_valid !== 1'b1 || obs_out !== vec_e[i]) begin
                n_fail++;
                $display("FAIL mode%0d: got v=%b out=%h expected v=1 out=%h", vec_m[i],
                         obs_valid, obs_out, vec_e[i]);
            end
        end
    endtask

    task automatic test_acc();
        logic acc_o;
        logic [W-1:0] va[4] = '{8'h01, 8'h04, 8'h10, 8'h00};
        logic [W-1:0] vb[4] = '{8'h02, 8'h00, 8'h10, 8'h00};
        logic [1:0]   vm[4] = '{2'd3, 2'd3, 2'd0, 2'd3};
        logic [W-1:0] ve[4] = '{8'h03, 8'h07, 8'h00, 8'h07};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; a = va[i]; b = vb[i]; mode = vm[i];
            end else begin
                in_valid = 1'b0;
            end
            cycle(acc_o);
            if (i > 0) begin
                n_checks++;
                if (obs_valid !== 1'b1 || obs_out !== ve[i-1]) begin
                    n_fail++;
                    $display("FAIL acc_seq%0d: got v=%b out=%h expected v=1 out=%h", i - 1,
                             obs_valid, obs_out, ve[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic acc_o;
        int n_acc;
        logic [W-1:0] held;
        n_acc = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); mode = 2'($urandom);
            cycle(acc_o);
            if (acc_o) n_acc++;
            if (!acc_o) break;
        end
        // third beat is now presented and blocked
        cycle(acc_o);
        held = obs_out;
        n_checks++;
        if (n_acc !== 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_fill: got accepted=%0d in_ready=%b expected accepted=2 in_ready=0",
                     n_acc, in_ready);
        end
        for (int i = 0; i < 3; i++) cycle(acc_o);
        n_checks++;
        if (obs_out !== held || obs_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: got out=%h v=%b expected out=%h v=1", obs_out, obs_valid, held);
        end
        out_ready = 1'b1;
        begin
            int budget;
            budget = 0;
            acc_o = 1'b0;
            while (!acc_o && budget < 10) begin
                cycle(acc_o);
                budget++;
            end
            n_checks++;
            if (!acc_o) begin
                n_fail++;
                $display("FAIL stall_third: got no accept in 10 cycles expected accept");
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle(acc_o);
    endtask

    task automatic test_back_to_back();
        logic acc_o;
        int start;
        int n_rdy;
        out_ready = 1'b1;
        n_rdy = 0;
        start = n_consumed;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = W'($urandom); b = W'($urandom); mode = 2'($urandom);
            cycle(acc_o);
            if (acc_o) n_rdy++;
        end
        in_valid = 1'b0;
        cycle(acc_o);
        n_checks++;
        if (n_rdy !== 16 || (n_consumed - start) !== 16 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL back_to_back: got accepted=%0d results=%0d expected 16 and 16",
                     n_rdy, n_consumed - start);
        end
    endtask

    task automatic test_reset_mid();
        logic acc_o;
        do_reset();
        out_ready = 1'b0;
        beat(8'h5A, 8'h00, 2'd3);
        beat(8'h33, 8'h11, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
        exp_q.delete();
`ifdef XOR_PIPE_PARITY_EN
        par_q.delete();
`endif
        acc_m = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle(acc_o);
        beat(8'h01, 8'h00, 2'd3);
        cycle(acc_o);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_out !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_acc: got v=%b out=%h expected v=1 out=01", obs_valid, obs_out);
        end
    endtask

    task automatic test_random();
        logic acc_o;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = W'($urandom); b = W'($urandom); mode = 2'($urandom);
            cycle(acc_o);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle(acc_o);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        n_consumed = 0;
        acc_m = '0;
        test_reset();
        test_modes();
        test_acc();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
